rgb_fade_mixer: RTL and testbench

//   Parametrised successor to the fixed 3x8-bit colour mixer. CH PWM channels of W-bit duty.

---
 rtl/rgb_fade_mixer.sv | 170 +++++++++++++++++
 tb/tb_rgb_fade_mixer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_mixer.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fade_mixer
// Description : CH-channel PWM colour mixer. Each channel's duty fades
//               linearly toward a target accepted over valid/ready, changing
//               by at most STEP per PWM frame. Flags a timeout once the
//               colour has been held for HOLD_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_mixer #(
  parameter int CH          = 3,
  parameter int W           = 8,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CH*W-1:0] color_i,
  input  logic            color_valid_i,
  output logic            color_ready_o,
  output logic [CH-1:0]   pwm_o,
  output logic            frame_o,
  output logic            busy_o,
  output logic            timeout_o
);

  // PWM period is 2^W-1 cycles, so cnt runs 0..2^W-2 and the last count is 2^W-2.
  localparam int unsigned C_PERIOD   = (1 << W) - 1;
  localparam logic [W-1:0] C_CNT_LAST = W'(C_PERIOD - 1);
  localparam logic [W:0]   C_STEP     = (W+1)'(STEP);
  localparam int           C_HW       = $clog2(HOLD_FRAMES + 1);
  localparam logic [C_HW-1:0] C_HOLD  = C_HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FADE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][W-1:0]  duty_q, duty_d;
  logic [CH-1:0][W-1:0]  target_q, target_d;
  logic [CH-1:0]         pwm_q, pwm_d;
  logic                  frame_q, frame_d;
  logic                  timeout_q, timeout_d;
  logic [C_HW-1:0]       hold_cnt_q, hold_cnt_d;

  logic                  w_boundary;
  logic                  w_accept;
  logic                  w_all_done;
  logic [CH-1:0][W-1:0]  w_duty_nxt;

  // Move cur toward tgt by at most STEP; the W+1-bit difference can never wrap.
  function automatic logic [W-1:0] f_approach(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
    logic [W:0] diff;
    logic [W:0] mv;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      mv   = (diff > C_STEP) ? C_STEP : diff;
      return cur + mv[W-1:0];
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      mv   = (diff > C_STEP) ? C_STEP : diff;
      return cur - mv[W-1:0];
    end
  endfunction

  // Frame counter, PWM compare and frame pulse; the pulse lands on the cnt==0 cycle.
  always_comb begin
    w_boundary = (cnt_q == C_CNT_LAST);
    cnt_d      = w_boundary ? '0 : cnt_q + 1'b1;
    frame_d    = w_boundary;
    for (int c = 0; c < CH; c++) begin
      pwm_d[c] = (cnt_q < duty_q[c]);
    end
  end

  // Candidate duties for the next boundary and whether they all land on target.
  always_comb begin
    w_all_done = 1'b1;
    w_duty_nxt = duty_q;
    for (int c = 0; c < CH; c++) begin
      w_duty_nxt[c] = f_approach(duty_q[c], target_q[c]);
      if (w_duty_nxt[c] != target_q[c]) begin
        w_all_done = 1'b0;
      end
    end
  end

  // Control FSM: accept targets, step duties at boundaries, count held frames.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    w_accept   = color_valid_i && (state_q != S_FADE);

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          target_d   = color_i;
          state_d    = S_FADE;
          hold_cnt_d = '0;
          timeout_d  = 1'b0;
        end
      end
      S_FADE: begin
        if (w_boundary) begin
          duty_d = w_duty_nxt;
          if (w_all_done) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // An accept on a boundary cycle wins over the hold count.
        if (w_accept) begin
          target_d   = color_i;
          state_d    = S_FADE;
          hold_cnt_d = '0;
          timeout_d  = 1'b0;
        end else if (w_boundary) begin
          if (hold_cnt_q != C_HOLD) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
          if (hold_cnt_d == C_HOLD) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      target_q   <= '0;
      pwm_q      <= '0;
      frame_q    <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      pwm_q      <= pwm_d;
      frame_q    <= frame_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign color_ready_o = (state_q != S_FADE);
  assign busy_o        = (state_q == S_FADE);
  assign pwm_o         = pwm_q;
  assign frame_o       = frame_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_fade_mixer
// Description : Directed, table-driven bench for rgb_fade_mixer
//               (CH=3, W=8, STEP=16, HOLD_FRAMES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_mixer;

  localparam int CH   = 3;
  localparam int W    = 8;
  localparam int STEP = 16;
  localparam int HOLD = 4;
  localparam int P    = 255;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [CH*W-1:0] color_i;
  logic            color_valid_i;
  logic            color_ready_o;
  logic [CH-1:0]   pwm_o;
  logic            frame_o;
  logic            busy_o;
  logic            timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rgb_fade_mixer #(
    .CH         (CH),
    .W          (W),
    .STEP       (STEP),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .color_i      (color_i),
    .color_valid_i(color_valid_i),
    .color_ready_o(color_ready_o),
    .pwm_o        (pwm_o),
    .frame_o      (frame_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  typedef struct {
    bit          send;
    logic [23:0] color;
    int          nfr;
    int          e0;
    int          e1;
    int          e2;
    bit          busy;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One-cycle valid pulse, launched on a falling edge.
  task automatic send(input logic [23:0] col);
    color_i       = col;
    color_valid_i = 1'b1;
    @(negedge clk);
    color_valid_i = 1'b0;
  endtask

  // Advance to the n-th following frame-start cycle (bounded wait).
  task automatic goto_frame(input int n);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!frame_o && guard < 2 * P) begin
        @(negedge clk);
        guard++;
      end
      check("frame_wait", int'(frame_o), 1);
    end
  endtask

  // Count high cycles per channel over one full frame (starting at a frame cycle).
  task automatic measure(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (P) begin
      @(negedge clk);
      c0 += int'(pwm_o[0]);
      c1 += int'(pwm_o[1]);
      c2 += int'(pwm_o[2]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, m1, m2;
    int guard;
    int hi;

    // send, colour, frames to advance, expected ch0/ch1/ch2 duty, busy
    tbl[0]  = '{1'b1, 24'h404040,  1,  16,  16,  16, 1'b1};
    tbl[1]  = '{1'b0, 24'h000000,  0,  32,  32,  32, 1'b1};
    tbl[2]  = '{1'b0, 24'h000000,  0,  48,  48,  48, 1'b1};
    tbl[3]  = '{1'b0, 24'h000000,  0,  64,  64,  64, 1'b0};
    tbl[4]  = '{1'b1, 24'h452010,  1,  48,  48,  69, 1'b1};
    tbl[5]  = '{1'b0, 24'h000000,  0,  32,  32,  69, 1'b1};
    tbl[6]  = '{1'b0, 24'h000000,  0,  16,  32,  69, 1'b0};
    tbl[7]  = '{1'b1, 24'h000000,  1,   0,  16,  53, 1'b1};
    tbl[8]  = '{1'b0, 24'h000000,  0,   0,   0,  37, 1'b1};
    tbl[9]  = '{1'b0, 24'h000000,  0,   0,   0,  21, 1'b1};
    tbl[10] = '{1'b0, 24'h000000,  0,   0,   0,   5, 1'b1};
    tbl[11] = '{1'b0, 24'h000000,  0,   0,   0,   0, 1'b0};
    tbl[12] = '{1'b1, 24'h0000ff, 16, 255,   0,   0, 1'b0};

    rst_ni        = 1'b0;
    color_i       = '0;
    color_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm",     int'(pwm_o),         0);
    check("rst_frame",   int'(frame_o),       0);
    check("rst_busy",    int'(busy_o),        0);
    check("rst_timeout", int'(timeout_o),     0);
    check("rst_ready",   int'(color_ready_o), 1);
    rst_ni = 1'b1;

    // Fade-up, clipped step-up, fade-down with clipped last step, full-scale duty.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].send) send(tbl[i].color);
      goto_frame(tbl[i].nfr);
      check($sformatf("row%0d_busy", i), int'(busy_o), int'(tbl[i].busy));
      measure(m0, m1, m2);
      check($sformatf("row%0d_ch0", i), m0, tbl[i].e0);
      check($sformatf("row%0d_ch1", i), m1, tbl[i].e1);
      check($sformatf("row%0d_ch2", i), m2, tbl[i].e2);
    end

    // Timeout: HOLD entered at a boundary; now one HOLD boundary has passed.
    check("hold1_timeout", int'(timeout_o), 0);
    goto_frame(2);
    check("hold3_timeout", int'(timeout_o), 0);
    repeat (P - 1) @(negedge clk);
    check("hold4_bnd_frame",   int'(frame_o),   0);
    check("hold4_bnd_timeout", int'(timeout_o), 0);
    @(negedge clk);
    check("hold4_frame",   int'(frame_o),       1);
    check("hold4_timeout", int'(timeout_o),     1);
    check("hold4_ready",   int'(color_ready_o), 1);

    // New accept clears timeout and starts a fade on the next cycle.
    send(24'h000000);
    check("reaccept_timeout", int'(timeout_o),     0);
    check("reaccept_busy",    int'(busy_o),        1);
    check("reaccept_ready",   int'(color_ready_o), 0);

    // Valid during FADE is ignored; fade still ends at the original target.
    repeat (10) @(negedge clk);
    color_i       = 24'hffffff;
    color_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fade_ready", int'(color_ready_o), 0);
    end
    color_valid_i = 1'b0;
    guard = 0;
    do begin
      goto_frame(1);
      guard++;
    end while (busy_o && guard < 20);
    check("ignore_fade_done", int'(busy_o), 0);
    measure(m0, m1, m2);
    check("ignore_ch0", m0, 0);
    check("ignore_ch1", m1, 0);
    check("ignore_ch2", m2, 0);

    // Asynchronous reset mid-fade.
    send(24'h808080);
    goto_frame(2);
    repeat (5) @(negedge clk);
    check("prerst_pwm", int'(pwm_o), 7);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_pwm",     int'(pwm_o),         0);
    check("arst_frame",   int'(frame_o),       0);
    check("arst_busy",    int'(busy_o),        0);
    check("arst_timeout", int'(timeout_o),     0);
    check("arst_ready",   int'(color_ready_o), 1);
    @(negedge clk);
    rst_ni = 1'b1;
    hi = 0;
    repeat (2 * P) begin
      @(negedge clk);
      hi += int'(pwm_o != 3'b000);
    end
    check("postrst_pwm_high", hi, 0);
    check("postrst_busy", int'(busy_o), 0);

    // Recovers with a fresh accept.
    send(24'h000010);
    goto_frame(1);
    measure(m0, m1, m2);
    check("recover_ch0", m0, 16);
    check("recover_ch1", m1, 0);
    check("recover_ch2", m2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
